// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver control slice.
//   rx_state_e         : receiver FSM states
//   PAR_EVEN / PAR_ODD : encodings of the par_typ input
//   DEF_DATA_WIDTH     : default number of data bits per frame
//   DEF_PRESCALE       : default oversampling clocks per bit
`timescale 1ns/1ps
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PRESCALE   = 16;

endpackage

// File: rtl/uart_rx_par_chk.sv
// Expected parity bit for a received data word.
//   data    : assembled data bits
//   par_typ : PAR_EVEN or PAR_ODD
//   par_exp : the parity bit the transmitter should have sent
`timescale 1ns/1ps
module uart_rx_par_chk
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_exp
);

  // Even parity: the bit makes the total count of ones even; odd inverts it.
  assign par_exp = (par_typ == PAR_EVEN) ? (^data) : ~(^data);

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM. Detects the start bit, enables the external
// sampler and edge/bit counter, deserializes LSB-first on each decision edge
// (edge_cnt == PRESCALE-1), checks parity and stop bit, and reports the frame
// on the cycle after the stop-bit decision.
//   clk, rst       : clock, asynchronous active-low reset
//   rx_in          : serial line (idle high), only looked at in IDLE
//   par_en/par_typ : parity config, captured when a frame starts
//   edge_cnt       : oversample index within the current bit
//   bit_cnt        : bit index within the frame, 0 = start bit
//   sampled_bit    : sampler decision for the current bit
//   dat_samp_en    : sampler enable
//   enable         : counter enable (counter holds 0/0 while low)
//   p_out          : last good byte
//   data_valid     : one-cycle strobe, p_out just updated
//   par_err        : one-cycle strobe, parity mismatch
//   stp_err        : one-cycle strobe, stop bit sampled 0
//   strt_glitch    : one-cycle strobe, start bit sampled 1
`timescale 1ns/1ps
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PRESCALE   = DEF_PRESCALE,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [CNT_W-1:0]      edge_cnt,
  input  logic [CNT_W-1:0]      bit_cnt,
  input  logic                  sampled_bit,
  output logic                  dat_samp_en,
  output logic                  enable,
  output logic [DATA_WIDTH-1:0] p_out,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch
);

  localparam logic [CNT_W-1:0] DE_CNT    = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH);

  rx_state_e             state, state_nxt;
  logic                  de;
  logic                  start_bad;
  logic                  par_en_q, par_typ_q;
  logic                  par_flag;
  logic                  par_exp;
  logic [DATA_WIDTH-1:0] shreg;

  assign de        = (edge_cnt == DE_CNT);
  assign start_bad = de && (bit_cnt == '0) && sampled_bit;

  uart_rx_par_chk #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_par_chk (
    .data    (shreg),
    .par_typ (par_typ_q),
    .par_exp (par_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    enable      = 1'b0;
    dat_samp_en = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_in) state_nxt = START;
      end
      START: begin
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        if (de) state_nxt = start_bad ? IDLE : DATA;
      end
      DATA: begin
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        if (de && (bit_cnt == LAST_DATA)) state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        if (de) state_nxt = STOP;
      end
      STOP: begin
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        if (de) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and strobes. Strobes default low so each lasts one clock; the
  // end-of-frame report is registered on the stop-bit decision edge, so it
  // lands in the first IDLE cycle even if a new start is detected there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      par_flag    <= 1'b0;
      shreg       <= '0;
      p_out       <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_in) begin
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
            par_flag  <= 1'b0;
            shreg     <= '0;
          end
        end
        START: begin
          if (start_bad) strt_glitch <= 1'b1;
        end
        DATA: begin
          // Shift right with new bit at the MSB: first bit received ends up at bit 0.
          if (de) shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
        end
        PARITY: begin
          if (de) par_flag <= (sampled_bit != par_exp);
        end
        STOP: begin
          if (de) begin
            par_err <= par_flag;
            stp_err <= ~sampled_bit;
            if (!par_flag && sampled_bit) begin
              data_valid <= 1'b1;
              p_out      <= shreg;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Testbench for uart_rx_fsm with behavioural sampler and edge/bit counter.
`timescale 1ns/1ps
module tb_uart_rx_fsm;
  import uart_rx_pkg::*;

  localparam int DW = 8;
  localparam int PS = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_in = 1'b1;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic [CW-1:0] edge_cnt;
  logic [CW-1:0] bit_cnt;
  logic          sampled_bit;
  logic          dat_samp_en;
  logic          enable;
  logic [DW-1:0] p_out;
  logic          data_valid, par_err, stp_err, strt_glitch;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [DW-1:0] exp_pout = '0;

  typedef struct {
    logic          dv;
    logic          pe;
    logic          se;
    logic          sg;
    logic [DW-1:0] p;
    int            cyc;
  } ev_t;
  ev_t evq[$];

  always #5 clk = ~clk;

  uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE(PS), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .sampled_bit (sampled_bit),
    .dat_samp_en (dat_samp_en),
    .enable      (enable),
    .p_out       (p_out),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .strt_glitch (strt_glitch)
  );

  // Edge/bit counter: holds 0/0 while disabled.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == CW'(PS - 1)) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 1'b1;
    end else begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  // Sampler: takes the line at mid-bit, stable well before the decision edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) sampled_bit <= 1'b0;
    else if (dat_samp_en && edge_cnt == CW'(PS / 2)) sampled_bit <= rx_in;
  end

  // Strobe monitor on the falling edge.
  always @(negedge clk) begin
    if (rst && (data_valid || par_err || stp_err || strt_glitch)) begin
      ev_t e;
      e.dv = data_valid; e.pe = par_err; e.se = stp_err; e.sg = strt_glitch;
      e.p = p_out; e.cyc = cyc;
      evq.push_back(e);
    end
    cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1);
  end

  // Drives one frame; entered and left just after a rising edge. The line is
  // left at the stop-bit level. Parity config is scrambled after the start bit.
  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input logic pbit, input logic stop);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pbit);
    bits.push_back(stop);
    par_en  = pe;
    par_typ = pt;
    for (int i = 0; i < bits.size(); i++) begin
      rx_in = bits[i];
      if (i == 1) begin
        par_en  = 1'($urandom);
        par_typ = 1'($urandom);
      end
      repeat (PS) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable got %b want 0", enable); end
    n_checks++; if (dat_samp_en !== 1'b0) begin n_fail++; $display("FAIL reset_samp_en got %b want 0", dat_samp_en); end
    n_checks++; if (p_out !== 8'h00) begin n_fail++; $display("FAIL reset_p_out got %h want 00", p_out); end
    n_checks++; if ({data_valid, par_err, stp_err, strt_glitch} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes got %b want 0000", {data_valid, par_err, stp_err, strt_glitch}); end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // One complete frame followed by idle, checked against the frame rules.
  task automatic test_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input logic pbit, input logic stop, input string nm);
    int   c0, nbits, ones, dly;
    logic ok, valid;
    c0    = cyc;
    nbits = pe ? DW + 3 : DW + 2;
    evq.delete();
    send_frame(d, pe, pt, pbit, stop);
    rx_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    ones  = $countones(d) + int'(pbit);
    ok    = (pt == PAR_ODD) ? (ones % 2 == 1) : (ones % 2 == 0);
    valid = stop && (!pe || ok);
    if (valid) exp_pout = d;
    n_checks++; if (evq.size() !== 1) begin
      n_fail++; $display("FAIL %s event_count got %0d want 1", nm, evq.size()); end
    if (evq.size() >= 1) begin
      dly = evq[0].cyc - c0;
      n_checks++; if (evq[0].dv !== valid) begin n_fail++; $display("FAIL %s data_valid got %b want %b", nm, evq[0].dv, valid); end
      n_checks++; if (evq[0].pe !== (pe && !ok)) begin n_fail++; $display("FAIL %s par_err got %b want %b", nm, evq[0].pe, pe && !ok); end
      n_checks++; if (evq[0].se !== !stop) begin n_fail++; $display("FAIL %s stp_err got %b want %b", nm, evq[0].se, !stop); end
      n_checks++; if (evq[0].sg !== 1'b0) begin n_fail++; $display("FAIL %s strt_glitch got %b want 0", nm, evq[0].sg); end
      n_checks++; if (evq[0].p !== exp_pout) begin n_fail++; $display("FAIL %s p_out_at_strobe got %h want %h", nm, evq[0].p, exp_pout); end
      n_checks++; if (dly < nbits * PS + 1 || dly > nbits * PS + 3) begin
        n_fail++; $display("FAIL %s report_latency got %0d want %0d..%0d", nm, dly, nbits * PS + 1, nbits * PS + 3); end
    end
    n_checks++; if (p_out !== exp_pout) begin n_fail++; $display("FAIL %s p_out_after got %h want %h", nm, p_out, exp_pout); end
    n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL %s enable_after got %b want 0", nm, enable); end
  endtask

  task automatic test_no_parity();
    test_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, "a5_nopar");
  endtask

  task automatic test_parity();
    test_frame(8'h3C, 1'b1, PAR_EVEN, 1'b0, 1'b1, "3c_even_ok");
    test_frame(8'h3C, 1'b1, PAR_EVEN, 1'b1, 1'b1, "3c_even_bad");
  endtask

  task automatic test_stop_err();
    test_frame(8'h81, 1'b1, PAR_ODD, 1'b1, 1'b0, "81_stop_bad");
  endtask

  task automatic test_glitch();
    evq.delete();
    rx_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    n_checks++; if (evq.size() !== 1) begin n_fail++; $display("FAIL glitch event_count got %0d want 1", evq.size()); end
    if (evq.size() >= 1) begin
      n_checks++; if ({evq[0].sg, evq[0].dv, evq[0].pe, evq[0].se} !== 4'b1000) begin
        n_fail++; $display("FAIL glitch strobes got %b want 1000", {evq[0].sg, evq[0].dv, evq[0].pe, evq[0].se}); end
    end
    n_checks++; if (p_out !== exp_pout) begin n_fail++; $display("FAIL glitch p_out got %h want %h", p_out, exp_pout); end
    n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL glitch enable got %b want 0", enable); end
  endtask

  task automatic test_back_to_back();
    int gap;
    evq.delete();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
    rx_in = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    exp_pout = 8'hF0;
    n_checks++; if (evq.size() !== 2) begin n_fail++; $display("FAIL b2b event_count got %0d want 2", evq.size()); end
    if (evq.size() >= 2) begin
      gap = evq[1].cyc - evq[0].cyc;
      n_checks++; if ({evq[0].dv, evq[0].p} !== {1'b1, 8'h55}) begin
        n_fail++; $display("FAIL b2b first got dv=%b p=%h want dv=1 p=55", evq[0].dv, evq[0].p); end
      n_checks++; if ({evq[1].dv, evq[1].p} !== {1'b1, 8'hF0}) begin
        n_fail++; $display("FAIL b2b second got dv=%b p=%h want dv=1 p=f0", evq[1].dv, evq[1].p); end
      n_checks++; if (gap < 10 * PS - 1 || gap > 10 * PS + 3) begin
        n_fail++; $display("FAIL b2b spacing got %0d want about %0d", gap, 10 * PS); end
    end
    n_checks++; if (p_out !== exp_pout) begin n_fail++; $display("FAIL b2b p_out got %h want %h", p_out, exp_pout); end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] d;
    d = 8'h12;
    evq.delete();
    par_en = 1'b0;
    rx_in  = 1'b0;
    repeat (PS) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rx_in = d[i];
      repeat (PS) @(posedge clk);
      #1;
    end
    n_checks++; if (enable !== 1'b1) begin n_fail++; $display("FAIL midrst busy_before got %b want 1", enable); end
    #1;
    rst = 1'b0;
    #1;
    exp_pout = '0;
    n_checks++; if ({enable, dat_samp_en} !== 2'b00) begin
      n_fail++; $display("FAIL midrst enables got %b want 00", {enable, dat_samp_en}); end
    n_checks++; if (p_out !== 8'h00) begin n_fail++; $display("FAIL midrst p_out got %h want 00", p_out); end
    n_checks++; if ({data_valid, par_err, stp_err, strt_glitch} !== 4'b0000) begin
      n_fail++; $display("FAIL midrst strobes got %b want 0000", {data_valid, par_err, stp_err, strt_glitch}); end
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (evq.size() !== 0) begin n_fail++; $display("FAIL midrst partial_report got %0d events want 0", evq.size()); end
    test_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, "34_after_rst");
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic pe, pt, pbit, stop;
    int ones;
    for (int n = 0; n < 8; n++) begin
      d    = DW'($urandom);
      pe   = 1'($urandom);
      pt   = 1'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      ones = $countones(d);
      // Correct parity bit most of the time, flipped otherwise.
      pbit = (pt == PAR_ODD) ? (ones % 2 == 0) : (ones % 2 == 1);
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      test_frame(d, pe, pt, pbit, stop, $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
